// File: rtl/vga_ring_pkg.sv
// Shared encodings and defaults for the concentric-ring VGA pattern engine.
package vga_ring_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [1:0] MODE_COLOR = 2'd0;
    localparam logic [1:0] MODE_GREY  = 2'd1;
    localparam logic [1:0] MODE_MONO  = 2'd2;
    localparam logic [1:0] MODE_INV   = 2'd3;

    typedef enum logic {
        AX_INC = 1'b0,
        AX_DEC = 1'b1
    } axis_state_e;

    // speed select 0..3 maps to a phase step of 1, 2, 4, 8
    function automatic logic [3:0] speed_step(input logic [1:0] spd);
        return 4'b0001 << spd;
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing ring centre: ping-pongs between LO and HI,
// advancing one unit per enabled step and reversing on reaching a limit.
module vga_bounce_axis
    import vga_ring_pkg::*;
#(
    parameter int LO   = 64,
    parameter int HI   = 576,
    parameter int INIT = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    output logic [9:0]  pos,
    output axis_state_e state
);

    localparam logic [9:0] LO_L   = 10'(LO);
    localparam logic [9:0] HI_L   = 10'(HI);
    localparam logic [9:0] INIT_L = 10'(INIT);

    logic [9:0]  pos_q, pos_d;
    axis_state_e state_q, state_d;

    always_comb begin
        pos_d   = pos_q;
        state_d = state_q;
        if (step_en) begin
            case (state_q)
                AX_INC: begin
                    pos_d = pos_q + 10'd1;
                    if (pos_d == HI_L) state_d = AX_DEC;
                end
                default: begin
                    pos_d = pos_q - 10'd1;
                    if (pos_d == LO_L) state_d = AX_INC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= INIT_L;
            state_q <= AX_INC;
        end else begin
            pos_q   <= pos_d;
            state_q <= state_d;
        end
    end

    assign pos   = pos_q;
    assign state = state_q;

endmodule

// File: rtl/vga_ring_engine.sv
// Concentric-ring pattern generator: 2-cycle registered pixel pipeline with
// syncs delayed alongside; animation and palette config change only at frame start.
module vga_ring_engine
    import vga_ring_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter int   COLOR_BITS = 2,
    parameter int   PHASE_W    = 10,
    parameter int   RING_SHIFT = 4,
    parameter int   MARGIN     = 64,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  display_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [1:0]            speed,
    input  logic                  direction,
    input  logic                  pause,
    input  logic [1:0]            mode,
    input  logic                  bounce,
    output logic [COLOR_BITS-1:0] r_out,
    output logic [COLOR_BITS-1:0] g_out,
    output logic [COLOR_BITS-1:0] b_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  frame_tick
);

    localparam int C     = COLOR_BITS;
    localparam int IDX_W = RING_SHIFT + 2 + C;
    localparam int EXT_W = (IDX_W > PHASE_W) ? IDX_W : PHASE_W;

    logic [9:0]         cx, cy;
    axis_state_e        x_state, y_state;
    logic               start, step_en;

    logic               at_origin_q, at_origin_d;
    logic               frame_tick_q, frame_tick_d;
    logic [1:0]         mode_q, mode_d;
    logic [PHASE_W-1:0] phase_q, phase_d, step;

    logic [10:0]        dx, dy, mx, mn;
    logic [11:0]        radius_q, radius_d;
    logic               disp1_q, disp1_d, hs1_q, hs1_d, vs1_q, vs1_d;

    logic [PHASE_W-1:0] anim;
    logic [EXT_W-1:0]   anim_ext;
    logic [C-1:0]       ri, gi, bi;
    logic [C-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs2_q, hs2_d, vs2_q, vs2_d;
    logic               unused_bits;

    assign at_origin_d = (hpos == 10'd0) && (vpos == 10'd0);
    assign start       = at_origin_d && !at_origin_q;
    assign step_en     = start && bounce && !pause;
    assign step        = PHASE_W'(speed_step(speed));

    vga_bounce_axis #(.LO(MARGIN), .HI(H_ACTIVE - MARGIN), .INIT(H_ACTIVE / 2)) u_axis_x (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .pos(cx), .state(x_state)
    );
    vga_bounce_axis #(.LO(MARGIN), .HI(V_ACTIVE - MARGIN), .INIT(V_ACTIVE / 2)) u_axis_y (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .pos(cy), .state(y_state)
    );

    always_comb begin
        frame_tick_d = start;
        mode_d       = start ? mode : mode_q;
        phase_d      = phase_q;
        if (start && !pause)
            phase_d = direction ? (phase_q - step) : (phase_q + step);

        // stage 1: octagonal distance approximation
        dx       = (hpos >= cx) ? 11'(hpos - cx) : 11'(cx - hpos);
        dy       = (vpos >= cy) ? 11'(vpos - cy) : 11'(cy - vpos);
        mx       = (dx >= dy) ? dx : dy;
        mn       = (dx >= dy) ? dy : dx;
        radius_d = 12'(mx) + 12'(mn >> 1);
        disp1_d  = display_on;
        hs1_d    = hsync_in;
        vs1_d    = vsync_in;

        // stage 2: ring index and palette
        anim     = radius_q[PHASE_W-1:0] + phase_q;
        anim_ext = EXT_W'(anim);
        ri       = anim_ext[RING_SHIFT +: C];
        gi       = anim_ext[RING_SHIFT+1 +: C];
        bi       = anim_ext[RING_SHIFT+2 +: C];
        case (mode_q)
            MODE_COLOR: begin r_d = ri;  g_d = gi;  b_d = bi;  end
            MODE_GREY:  begin r_d = gi;  g_d = gi;  b_d = gi;  end
            MODE_MONO:  begin
                r_d = {C{anim_ext[RING_SHIFT]}};
                g_d = r_d;
                b_d = r_d;
            end
            default:    begin r_d = ~ri; g_d = ~gi; b_d = ~bi; end
        endcase
        if (!disp1_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
        hs2_d = hs1_q;
        vs2_d = vs1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_origin_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            mode_q       <= 2'd0;
            phase_q      <= '0;
            radius_q     <= '0;
            disp1_q      <= 1'b0;
            hs1_q        <= SYNC_IDLE;
            vs1_q        <= SYNC_IDLE;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            hs2_q        <= SYNC_IDLE;
            vs2_q        <= SYNC_IDLE;
        end else begin
            at_origin_q  <= at_origin_d;
            frame_tick_q <= frame_tick_d;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            radius_q     <= radius_d;
            disp1_q      <= disp1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
        end
    end

    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign frame_tick  = frame_tick_q;
    assign unused_bits = ^{radius_q, anim_ext, x_state, y_state};

endmodule
